sw_core_param: RTL and testbench

SW_CORE_PARAM -- requirements
Module: sw_core_param

---
 rtl/sw_pkg.sv | 43 ++++
 rtl/sw_pe.sv | 118 +++++++++++
 rtl/sw_core_param.sv | 219 +++++++++++++++++++++
 tb/tb_sw_core_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman core: base encoding, FSM
// states, default scoring constants and the saturating adder used by
// every PE.
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_REDUCE,
    ST_DONE
  } state_t;

  localparam int DEF_MATCH      = 1;
  localparam int DEF_MISMATCH   = -4;
  localparam int DEF_GAP_OPEN   = -6;
  localparam int DEF_GAP_EXTEND = -1;

  // Adds two sign-extended operands and clamps the result to the signed
  // range of a w-bit word (w <= 31). Callers keep the low w bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sw_pe.sv
// One processing element of the systolic Smith-Waterman array. It owns one
// read base (one matrix row), computes one cell per cycle as the reference
// stream passes through, forwards the reference base one PE down the chain
// and keeps the row maximum with the column of its first occurrence.
module sw_pe
  import sw_pkg::*;
#(
  parameter int SCORE_W = 10,
  parameter int COL_W   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      active,
  input  logic [1:0]                read_base,
  input  logic [1:0]                ref_in,
  input  logic                      vld_in,
  input  logic signed [SCORE_W-1:0] h_top,
  input  logic signed [SCORE_W-1:0] f_top,
  input  logic signed [SCORE_W-1:0] match,
  input  logic signed [SCORE_W-1:0] mismatch,
  input  logic signed [SCORE_W-1:0] gap_open,
  input  logic signed [SCORE_W-1:0] gap_extend,
  output logic [1:0]                ref_out,
  output logic                      vld_out,
  output logic signed [SCORE_W-1:0] h,
  output logic signed [SCORE_W-1:0] f,
  output logic signed [SCORE_W-1:0] row_max,
  output logic [COL_W-1:0]          row_col
);

  localparam logic signed [SCORE_W-1:0] ZERO = '0;

  function automatic logic signed [SCORE_W-1:0] sadd(input logic signed [SCORE_W-1:0] a,
                                                     input logic signed [SCORE_W-1:0] b);
    logic signed [31:0] r;
    r = sat_add(32'(a), 32'(b), SCORE_W);
    return r[SCORE_W-1:0];
  endfunction

  function automatic logic signed [SCORE_W-1:0] smax(input logic signed [SCORE_W-1:0] a,
                                                     input logic signed [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [1:0]                ref_q;
  logic                      vld_q;
  logic signed [SCORE_W-1:0] h_q;
  logic signed [SCORE_W-1:0] e_q;
  logic signed [SCORE_W-1:0] f_q;
  logic signed [SCORE_W-1:0] hd_q;
  logic signed [SCORE_W-1:0] max_q;
  logic [COL_W-1:0]          maxcol_q;
  logic [COL_W-1:0]          col_cnt;

  logic                      cell_vld;
  logic signed [SCORE_W-1:0] s;
  logic signed [SCORE_W-1:0] e_n;
  logic signed [SCORE_W-1:0] f_n;
  logic signed [SCORE_W-1:0] h_n;

  // h_q/e_q are this row's left neighbour, h_top/f_top come from the row
  // above one cycle later, and hd_q is the row above delayed once more
  // (the diagonal). Rows beyond the read length never update.
  assign cell_vld = en && vld_in && active;
  assign s        = (read_base == ref_in) ? match : mismatch;
  assign e_n      = smax(sadd(h_q, gap_open), sadd(e_q, gap_extend));
  assign f_n      = smax(sadd(h_top, gap_open), sadd(f_top, gap_extend));
  assign h_n      = smax(smax(ZERO, sadd(hd_q, s)), smax(e_n, f_n));

  // Cell registers, reference forwarding and row-maximum tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q    <= '0;
      vld_q    <= 1'b0;
      h_q      <= '0;
      e_q      <= '0;
      f_q      <= '0;
      hd_q     <= '0;
      max_q    <= '0;
      maxcol_q <= '0;
      col_cnt  <= '0;
    end else if (clear) begin
      ref_q    <= '0;
      vld_q    <= 1'b0;
      h_q      <= '0;
      e_q      <= '0;
      f_q      <= '0;
      hd_q     <= '0;
      max_q    <= '0;
      maxcol_q <= '0;
      col_cnt  <= '0;
    end else if (en) begin
      ref_q <= ref_in;
      vld_q <= vld_in;
      hd_q  <= h_top;
      if (cell_vld) begin
        h_q     <= h_n;
        e_q     <= e_n;
        f_q     <= f_n;
        col_cnt <= col_cnt + 1'b1;
        if (h_n > max_q) begin
          max_q    <= h_n;
          maxcol_q <= col_cnt;
        end
      end
    end
  end

  assign ref_out = ref_q;
  assign vld_out = vld_q;
  assign h       = h_q;
  assign f       = f_q;
  assign row_max = max_q;
  assign row_col = maxcol_q;

endmodule

// File: rtl/sw_core_param.sv
// Smith-Waterman local alignment core with affine gaps. A job is latched,
// the reference streams diagonally through a chain of N_PE cells, then the
// per-row maxima are scanned to find the best cell (smallest row, then
// smallest column on ties).
module sw_core_param
  import sw_pkg::*;
#(
  parameter int N_PE    = 128,
  parameter int REF_MAX = 128,
  parameter int SCORE_W = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         o_ready,
  input  logic                         i_valid,
  input  logic [2*REF_MAX-1:0]         i_seq_ref,
  input  logic [2*N_PE-1:0]            i_seq_read,
  input  logic [$clog2(REF_MAX):0]     i_ref_len,
  input  logic [$clog2(N_PE):0]        i_read_len,
  input  logic signed [SCORE_W-1:0]    i_match,
  input  logic signed [SCORE_W-1:0]    i_mismatch,
  input  logic signed [SCORE_W-1:0]    i_gap_open,
  input  logic signed [SCORE_W-1:0]    i_gap_extend,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic signed [SCORE_W-1:0]    o_score,
  output logic [$clog2(N_PE)-1:0]      o_row,
  output logic [$clog2(REF_MAX)-1:0]   o_col,
  output logic                         o_err
);

  localparam int ROW_W = $clog2(N_PE);
  localparam int COL_W = $clog2(REF_MAX);
  localparam int RL_W  = COL_W + 1;
  localparam int RD_W  = ROW_W + 1;
  localparam int CNT_W = $clog2(N_PE + REF_MAX) + 1;

  state_t state;
  state_t state_n;

  logic [2*REF_MAX-1:0]      ref_sr;
  logic [2*N_PE-1:0]         read_q;
  logic [RL_W-1:0]           ref_len_q;
  logic [RD_W-1:0]           read_len_q;
  logic signed [SCORE_W-1:0] match_q;
  logic signed [SCORE_W-1:0] mismatch_q;
  logic signed [SCORE_W-1:0] gap_open_q;
  logic signed [SCORE_W-1:0] gap_extend_q;
  logic [CNT_W-1:0]          cnt;
  logic signed [SCORE_W-1:0] best_score;
  logic [ROW_W-1:0]          best_row;
  logic [COL_W-1:0]          best_col;
  logic                      err_q;

  logic                      len_bad;
  logic                      calc_last;
  logic                      red_last;
  logic                      feed_vld;
  logic                      pe_en;
  logic                      pe_clear;
  logic [ROW_W-1:0]          red_idx;

  logic [1:0]                ref_fwd [N_PE];
  logic                      vld_fwd [N_PE];
  logic signed [SCORE_W-1:0] h_out   [N_PE];
  logic signed [SCORE_W-1:0] f_out   [N_PE];
  logic signed [SCORE_W-1:0] pe_max  [N_PE];
  logic [COL_W-1:0]          pe_col  [N_PE];

  assign len_bad   = (ref_len_q == '0) || (ref_len_q > RL_W'(REF_MAX)) ||
                     (read_len_q == '0) || (read_len_q > RD_W'(N_PE));
  // The wavefront needs ref_len + read_len - 1 steps; cnt counts from 0.
  assign calc_last = (cnt == CNT_W'(ref_len_q) + CNT_W'(read_len_q) - CNT_W'(2));
  assign red_last  = (cnt == CNT_W'(read_len_q) - CNT_W'(1));
  assign feed_vld  = (state == ST_CALC) && (cnt < CNT_W'(ref_len_q));
  assign pe_en     = (state == ST_CALC);
  assign pe_clear  = (state == ST_LOAD);
  assign red_idx   = cnt[ROW_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (i_valid) state_n = ST_LOAD;
      ST_LOAD:   state_n = len_bad ? ST_DONE : ST_CALC;
      ST_CALC:   if (calc_last) state_n = ST_REDUCE;
      ST_REDUCE: if (red_last) state_n = ST_DONE;
      ST_DONE:   if (i_ready) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state)
      ST_IDLE: o_ready = 1'b1;
      ST_DONE: o_valid = 1'b1;
      default: ;
    endcase
  end

  // Job latch, reference shifter, step counter and best-cell reduction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sr       <= '0;
      read_q       <= '0;
      ref_len_q    <= '0;
      read_len_q   <= '0;
      match_q      <= '0;
      mismatch_q   <= '0;
      gap_open_q   <= '0;
      gap_extend_q <= '0;
      cnt          <= '0;
      best_score   <= '0;
      best_row     <= '0;
      best_col     <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            ref_sr       <= i_seq_ref;
            read_q       <= i_seq_read;
            ref_len_q    <= i_ref_len;
            read_len_q   <= i_read_len;
            match_q      <= i_match;
            mismatch_q   <= i_mismatch;
            gap_open_q   <= i_gap_open;
            gap_extend_q <= i_gap_extend;
            best_score   <= '0;
            best_row     <= '0;
            best_col     <= '0;
            err_q        <= 1'b0;
          end
        end
        ST_LOAD: begin
          err_q <= len_bad;
          cnt   <= '0;
        end
        ST_CALC: begin
          ref_sr <= ref_sr << 2;
          cnt    <= calc_last ? '0 : cnt + 1'b1;
        end
        ST_REDUCE: begin
          cnt <= cnt + 1'b1;
          if (pe_max[red_idx] > best_score) begin
            best_score <= pe_max[red_idx];
            best_row   <= red_idx;
            best_col   <= pe_col[red_idx];
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_PE; g++) begin : g_pe
    localparam logic [RD_W-1:0] PIDX = RD_W'(g);
    logic [1:0]                ref_in_g;
    logic                      vld_in_g;
    logic signed [SCORE_W-1:0] h_top_g;
    logic signed [SCORE_W-1:0] f_top_g;

    if (g == 0) begin : g_head
      assign ref_in_g = ref_sr[2*REF_MAX-1 -: 2];
      assign vld_in_g = feed_vld;
      assign h_top_g  = '0;
      assign f_top_g  = '0;
    end else begin : g_link
      assign ref_in_g = ref_fwd[g-1];
      assign vld_in_g = vld_fwd[g-1];
      assign h_top_g  = h_out[g-1];
      assign f_top_g  = f_out[g-1];
    end

    sw_pe #(
      .SCORE_W (SCORE_W),
      .COL_W   (COL_W)
    ) u_pe (
      .clk        (clk),
      .rst        (rst),
      .clear      (pe_clear),
      .en         (pe_en),
      .active     (PIDX < read_len_q),
      .read_base  (read_q[2*N_PE-1-2*g -: 2]),
      .ref_in     (ref_in_g),
      .vld_in     (vld_in_g),
      .h_top      (h_top_g),
      .f_top      (f_top_g),
      .match      (match_q),
      .mismatch   (mismatch_q),
      .gap_open   (gap_open_q),
      .gap_extend (gap_extend_q),
      .ref_out    (ref_fwd[g]),
      .vld_out    (vld_fwd[g]),
      .h          (h_out[g]),
      .f          (f_out[g]),
      .row_max    (pe_max[g]),
      .row_col    (pe_col[g])
    );
  end

  assign o_score = best_score;
  assign o_row   = best_row;
  assign o_col   = best_col;
  assign o_err   = err_q;

endmodule

// File: tb/tb_sw_core_param.sv
// Directed bench for sw_core_param: a default-sized instance for the
// alignment, error, hold and abort cases, and a small 6-bit-score instance
// for score saturation.
module tb_sw_core_param;
  import sw_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic               o_ready;
  logic               i_valid = 1'b0;
  logic [255:0]       i_seq_ref = '0;
  logic [255:0]       i_seq_read = '0;
  logic [7:0]         i_ref_len = '0;
  logic [7:0]         i_read_len = '0;
  logic signed [9:0]  i_match = '0;
  logic signed [9:0]  i_mismatch = '0;
  logic signed [9:0]  i_gap_open = '0;
  logic signed [9:0]  i_gap_extend = '0;
  logic               i_ready = 1'b0;
  logic               o_valid;
  logic signed [9:0]  o_score;
  logic [6:0]         o_row;
  logic [6:0]         o_col;
  logic               o_err;

  // Narrow-score instance.
  logic               o_ready_b;
  logic               i_valid_b = 1'b0;
  logic [127:0]       i_seq_ref_b = '0;
  logic [127:0]       i_seq_read_b = '0;
  logic [6:0]         i_ref_len_b = '0;
  logic [6:0]         i_read_len_b = '0;
  logic signed [5:0]  i_match_b = '0;
  logic signed [5:0]  i_mismatch_b = '0;
  logic signed [5:0]  i_gap_open_b = '0;
  logic signed [5:0]  i_gap_extend_b = '0;
  logic               i_ready_b = 1'b0;
  logic               o_valid_b;
  logic signed [5:0]  o_score_b;
  logic [5:0]         o_row_b;
  logic [5:0]         o_col_b;
  logic               o_err_b;

  int n_assert = 0;
  int n_fail   = 0;

  sw_core_param dut (
    .clk (clk), .rst (rst), .o_ready (o_ready), .i_valid (i_valid),
    .i_seq_ref (i_seq_ref), .i_seq_read (i_seq_read),
    .i_ref_len (i_ref_len), .i_read_len (i_read_len),
    .i_match (i_match), .i_mismatch (i_mismatch),
    .i_gap_open (i_gap_open), .i_gap_extend (i_gap_extend),
    .i_ready (i_ready), .o_valid (o_valid), .o_score (o_score),
    .o_row (o_row), .o_col (o_col), .o_err (o_err)
  );

  sw_core_param #(.N_PE (64), .REF_MAX (64), .SCORE_W (6)) dut_b (
    .clk (clk), .rst (rst), .o_ready (o_ready_b), .i_valid (i_valid_b),
    .i_seq_ref (i_seq_ref_b), .i_seq_read (i_seq_read_b),
    .i_ref_len (i_ref_len_b), .i_read_len (i_read_len_b),
    .i_match (i_match_b), .i_mismatch (i_mismatch_b),
    .i_gap_open (i_gap_open_b), .i_gap_extend (i_gap_extend_b),
    .i_ready (i_ready_b), .o_valid (o_valid_b), .o_score (o_score_b),
    .o_row (o_row_b), .o_col (o_col_b), .o_err (o_err_b)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input byte c);
    case (c)
      "C":     return BASE_C;
      "G":     return BASE_G;
      "T":     return BASE_T;
      default: return BASE_A;
    endcase
  endfunction

  function automatic logic [255:0] pack(input string s);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[255-2*i -: 2] = enc(s[i]);
    return v;
  endfunction

  // Drives one job into the default instance on a falling edge.
  task automatic start_job(input string rd, input string rf, input int rdl, input int rfl,
                           input int m, input int mm, input int go, input int ge);
    @(negedge clk);
    i_seq_read   = pack(rd);
    i_seq_ref    = pack(rf);
    i_read_len   = 8'(rdl);
    i_ref_len    = 8'(rfl);
    i_match      = 10'(m);
    i_mismatch   = 10'(mm);
    i_gap_open   = 10'(go);
    i_gap_extend = 10'(ge);
    i_valid      = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the inputs; the job in flight must not notice.
    i_valid      = 1'b0;
    i_seq_read   = {8{32'hA5C3_5A3C}};
    i_seq_ref    = '1;
    i_read_len   = 8'd2;
    i_ref_len    = 8'd3;
    i_match      = 10'sd5;
    i_mismatch   = 10'sd0;
    i_gap_open   = 10'sd0;
    i_gap_extend = 10'sd0;
  endtask

  task automatic release_result(input string tag);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, o_valid, 1'b0);
    check({tag, "_ready_back"}, o_ready, 1'b1);
  endtask

  task automatic run_job(input string tag, input string rd, input string rf,
                         input int m, input int mm, input int go, input int ge,
                         input int es, input int er, input int ec);
    int cyc;
    start_job(rd, rf, rd.len(), rf.len(), m, mm, go, ge);
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, rf.len() + 2 * rd.len());
    check({tag, "_score"}, o_score, es);
    check({tag, "_row"}, o_row, er);
    check({tag, "_col"}, o_col, ec);
    check({tag, "_err"}, o_err, 1'b0);
    release_result(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int highs;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_score", o_score, 0);
    check("rst_row", o_row, 0);
    check("rst_col", o_col, 0);
    check("rst_valid_b", o_valid_b, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", o_ready, 1'b1);
    check("ready_after_rst_b", o_ready_b, 1'b1);

    // Exact match, mismatch-only, and gapped alignments.
    run_job("acgt_acgt", "ACGT", "ACGT", 1, -4, -6, -1, 4, 3, 3);
    run_job("aaaa_cccc", "AAAA", "CCCC", DEF_MATCH, DEF_MISMATCH, DEF_GAP_OPEN,
            DEF_GAP_EXTEND, 0, 0, 0);
    run_job("acgat_def", "ACGT", "ACGAT", 1, -4, -6, -1, 3, 2, 2);
    run_job("acgat_gap", "ACGT", "ACGAT", 2, -4, -1, -1, 7, 3, 4);

    // Zero read length: error result one edge after acceptance, held.
    start_job("ACGT", "ACGT", 0, 4, 1, -4, -6, -1);
    check("err_not_early", o_valid, 1'b0);
    @(posedge clk);
    #1;
    check("err_valid", o_valid, 1'b1);
    check("err_flag", o_err, 1'b1);
    check("err_score", o_score, 0);
    check("err_row", o_row, 0);
    check("err_col", o_col, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("err_hold_valid", o_valid, 1'b1);
      check("err_hold_flag", o_err, 1'b1);
      check("err_hold_score", o_score, 0);
    end
    release_result("err");

    // Reference length above the maximum is also an error.
    start_job("ACGT", "ACGT", 4, 129, 1, -4, -6, -1);
    @(posedge clk);
    #1;
    check("errref_valid", o_valid, 1'b1);
    check("errref_flag", o_err, 1'b1);
    release_result("errref");

    // A clean job after an error job must report o_err low again.
    run_job("after_err", "ACGT", "ACGT", 1, -4, -6, -1, 4, 3, 3);

    // Reset during CALC aborts the job.
    start_job("ACGT", "ACGT", 4, 4, 1, -4, -6, -1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("abort_valid_in_rst", o_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", o_ready, 1'b1);
    check("abort_score", o_score, 0);
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (o_valid !== 1'b0) highs++;
    end
    check("abort_no_result", highs, 0);
    run_job("recover", "ACGT", "ACGT", 1, -4, -6, -1, 4, 3, 3);

    // Saturation on the 6-bit instance: 40 identical A bases.
    @(negedge clk);
    i_seq_read_b   = '0;
    i_seq_ref_b    = '0;
    i_read_len_b   = 7'd40;
    i_ref_len_b    = 7'd40;
    i_match_b      = 6'(DEF_MATCH);
    i_mismatch_b   = 6'(DEF_MISMATCH);
    i_gap_open_b   = 6'(DEF_GAP_OPEN);
    i_gap_extend_b = 6'(DEF_GAP_EXTEND);
    i_valid_b      = 1'b1;
    @(posedge clk);
    #1;
    i_valid_b = 1'b0;
    cyc = 0;
    while (o_valid_b !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sat_latency", cyc, 120);
    check("sat_score", o_score_b, 31);
    check("sat_row", o_row_b, 30);
    check("sat_col", o_col_b, 30);
    check("sat_err", o_err_b, 1'b0);
    i_ready_b = 1'b1;
    @(posedge clk);
    #1;
    i_ready_b = 1'b0;
    check("sat_valid_drop", o_valid_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
